// File: rtl/command_credit_arbiter.sv
// -----------------------------------------------------------------------------
// command_credit_arbiter
//   Shares the single PSL command interface between the AFU command producers
//   (0 = WED, 1 = read, 2 = write, 3 = pf-read, 4 = pf-write) under PSL credit
//   flow control. Round-robin grant, credit / outstanding accounting, tag
//   generation and drain-on-disable sequencing.
//
// Ports
//   clock, rstn            rising-edge clock, async active-low reset
//   enabled_in             job running; 0 stops new grants and starts a drain
//   credit_load_in         pulse in IDLE: load room_in as credits and max credit
//   room_in                initial PSL credit count
//   response_valid_in      PSL response: returns a credit, retires a command
//   req_valid_in           per-requester command valid
//   req_cmd_in             per-requester command, slice i = requester i
//   req_ready_out          one-hot grant (source dequeues the same cycle)
//   command_valid_out      registered issue strobe to PSL
//   command_out            registered granted command
//   command_tag_out        tag attached to the issued command
//   command_src_out        index of the granted requester
//   credits_out            available credits
//   outstanding_out        commands issued but not yet responded
//   drained_out            1 in DRAIN once nothing is outstanding
//   credit_overflow_error  sticky: credit returned at max, or response with
//                          nothing outstanding
// -----------------------------------------------------------------------------
module command_credit_arbiter #(
    parameter int NUM_REQ   = 5,
    parameter int CMD_WIDTH = 128,
    parameter int CREDIT_W  = 8
) (
    input  logic                         clock,
    input  logic                         rstn,
    input  logic                         enabled_in,
    input  logic                         credit_load_in,
    input  logic [CREDIT_W-1:0]          room_in,
    input  logic                         response_valid_in,
    input  logic [NUM_REQ-1:0]           req_valid_in,
    input  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd_in,
    output logic [NUM_REQ-1:0]           req_ready_out,
    output logic                         command_valid_out,
    output logic [CMD_WIDTH-1:0]         command_out,
    output logic [CREDIT_W-1:0]          command_tag_out,
    output logic [2:0]                   command_src_out,
    output logic [CREDIT_W-1:0]          credits_out,
    output logic [CREDIT_W-1:0]          outstanding_out,
    output logic                         drained_out,
    output logic                         credit_overflow_error
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [PTR_W-1:0]      r_rr_ptr;
    logic [CREDIT_W-1:0]   r_tag;
    logic [CREDIT_W-1:0]   r_credits, w_credits_nxt;
    logic [CREDIT_W-1:0]   r_max_credit;
    logic [CREDIT_W-1:0]   r_outstanding, w_out_nxt;
    logic                  r_err, w_err_set;
    logic                  r_cmd_valid;
    logic [CMD_WIDTH-1:0]  r_cmd;
    logic [CREDIT_W-1:0]   r_cmd_tag;
    logic [PTR_W-1:0]      r_cmd_src;

    logic                  w_load;
    logic                  w_grant_en;
    logic                  w_drained;
    logic                  w_grant;
    logic [PTR_W-1:0]      w_grant_idx;
    logic [NUM_REQ-1:0]    w_grant_vec;

    // Reload is only honoured while idle.
    assign w_load = (r_state == IDLE) && credit_load_in;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (credit_load_in) w_state_nxt = RUN;
            RUN:     if (!enabled_in) w_state_nxt = DRAIN;
            DRAIN:   if (r_outstanding == '0 && !response_valid_in) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_grant_en = (r_state == RUN) && enabled_in && (r_credits != '0);
        w_drained  = (r_state == DRAIN) && (r_outstanding == '0);
    end

    // Round-robin search starting at r_rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        logic [PTR_W:0] v_idx;
        w_grant     = 1'b0;
        w_grant_idx = '0;
        w_grant_vec = '0;
        v_idx       = '0;
        if (w_grant_en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                v_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
                if (v_idx >= (PTR_W+1)'(NUM_REQ))
                    v_idx = v_idx - (PTR_W+1)'(NUM_REQ);
                if (!w_grant && req_valid_in[v_idx[PTR_W-1:0]]) begin
                    w_grant     = 1'b1;
                    w_grant_idx = v_idx[PTR_W-1:0];
                end
            end
        end
        if (w_grant) w_grant_vec[w_grant_idx] = 1'b1;
    end

    // Credit / outstanding accounting. A returned credit at the loaded max is
    // dropped (saturate) and flagged; so is a response with nothing in flight.
    always_comb begin
        w_credits_nxt = r_credits;
        w_out_nxt     = r_outstanding;
        w_err_set     = 1'b0;
        if (w_load) begin
            w_credits_nxt = room_in;
        end else if (response_valid_in && !w_grant) begin
            if (r_credits == r_max_credit) w_err_set = 1'b1;
            else                           w_credits_nxt = r_credits + 1'b1;
        end else if (w_grant && !response_valid_in) begin
            w_credits_nxt = r_credits - 1'b1;
        end

        if (response_valid_in && r_outstanding == '0) begin
            w_err_set = 1'b1;
            w_out_nxt = r_outstanding + CREDIT_W'(w_grant);
        end else begin
            w_out_nxt = r_outstanding + CREDIT_W'(w_grant) - CREDIT_W'(response_valid_in);
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_rr_ptr      <= '0;
            r_tag         <= '0;
            r_credits     <= '0;
            r_max_credit  <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
            r_cmd_valid   <= 1'b0;
            r_cmd         <= '0;
            r_cmd_tag     <= '0;
            r_cmd_src     <= '0;
        end else begin
            r_credits     <= w_credits_nxt;
            r_outstanding <= w_out_nxt;
            r_err         <= w_load ? 1'b0 : (r_err | w_err_set);
            r_cmd_valid   <= w_grant;
            if (w_load) r_max_credit <= room_in;
            if (w_grant) begin
                r_rr_ptr  <= (w_grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : w_grant_idx + 1'b1;
                r_tag     <= r_tag + 1'b1;
                r_cmd     <= req_cmd_in[w_grant_idx*CMD_WIDTH +: CMD_WIDTH];
                r_cmd_tag <= r_tag;
                r_cmd_src <= w_grant_idx;
            end
        end
    end

    assign req_ready_out         = w_grant_vec;
    assign command_valid_out     = r_cmd_valid;
    assign command_out           = r_cmd;
    assign command_tag_out       = r_cmd_tag;
    assign command_src_out       = 3'(r_cmd_src);
    assign credits_out           = r_credits;
    assign outstanding_out       = r_outstanding;
    assign drained_out           = w_drained;
    assign credit_overflow_error = r_err;

endmodule

// File: tb/tb_command_credit_arbiter.sv
// Randomised + directed bench for command_credit_arbiter. A queue-based
// scoreboard holds the expected issued commands; a monitor on the falling
// edge compares issues and the accounting outputs against a behavioural model.
module tb_command_credit_arbiter;
    localparam int N  = 5;
    localparam int CW = 128;

    logic            clock = 1'b0;
    logic            rstn  = 1'b0;
    logic            enabled_in = 1'b0;
    logic            credit_load_in = 1'b0;
    logic [7:0]      room_in = '0;
    logic            response_valid_in = 1'b0;
    logic [N-1:0]    req_valid_in = '0;
    logic [N*CW-1:0] req_cmd_in = '0;
    logic [N-1:0]    req_ready_out;
    logic            command_valid_out;
    logic [CW-1:0]   command_out;
    logic [7:0]      command_tag_out;
    logic [2:0]      command_src_out;
    logic [7:0]      credits_out;
    logic [7:0]      outstanding_out;
    logic            drained_out;
    logic            credit_overflow_error;

    command_credit_arbiter dut (
        .clock(clock), .rstn(rstn), .enabled_in(enabled_in),
        .credit_load_in(credit_load_in), .room_in(room_in),
        .response_valid_in(response_valid_in), .req_valid_in(req_valid_in),
        .req_cmd_in(req_cmd_in), .req_ready_out(req_ready_out),
        .command_valid_out(command_valid_out), .command_out(command_out),
        .command_tag_out(command_tag_out), .command_src_out(command_src_out),
        .credits_out(credits_out), .outstanding_out(outstanding_out),
        .drained_out(drained_out), .credit_overflow_error(credit_overflow_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [CW-1:0] cmd;
        int            src;
        int            tag;
    } exp_t;

    exp_t q[$];
    int   errs = 0;
    int   checks = 0;

    // Behavioural model: mode 0 idle, 1 running, 2 draining.
    int m_mode, m_cred, m_max, m_out, m_tag, m_rr;
    bit m_err;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cred = 0; m_max = 0; m_out = 0; m_tag = 0; m_rr = 0; m_err = 0;
        q.delete();
    endtask

    function automatic logic [255:0] all_outs();
        return 256'({req_ready_out, command_valid_out, command_out, command_tag_out,
                     command_src_out, credits_out, outstanding_out, drained_out,
                     credit_overflow_error});
    endfunction

    // One clock cycle of stimulus; grant checked combinationally, model
    // advanced at the rising edge.
    task automatic step(input bit en, input bit ld, input int room, input bit resp,
                        input logic [N-1:0] vld);
        int   g;
        int   gb;
        int   old_out;
        bit   ldi;
        exp_t e;
        logic [N*CW-1:0] cmds;
        logic [N-1:0]    exp_rdy;
        @(negedge clock);
        for (int i = 0; i < N; i++)
            cmds[i*CW +: CW] = {$urandom, $urandom, $urandom, $urandom};
        enabled_in        = en;
        credit_load_in    = ld;
        room_in           = 8'(room);
        response_valid_in = resp;
        req_valid_in      = vld;
        req_cmd_in        = cmds;
        #1;
        g = -1;
        if (m_mode == 1 && en && m_cred != 0) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && vld[(m_rr + k) % N]) g = (m_rr + k) % N;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("grant", 256'(req_ready_out), 256'(exp_rdy));
        if (g >= 0) begin
            e.cmd = cmds[g*CW +: CW];
            e.src = g;
            e.tag = m_tag;
            q.push_back(e);
        end
        @(posedge clock);
        gb      = (g >= 0) ? 1 : 0;
        ldi     = (m_mode == 0) && ld;
        old_out = m_out;
        if (ldi) begin
            m_cred = room; m_max = room;
        end else if (resp && gb == 0 && m_cred == m_max) begin
            m_err = 1;
        end else begin
            m_cred = m_cred - gb + (resp ? 1 : 0);
        end
        if (resp && m_out == 0) begin
            m_err = 1; m_out = m_out + gb;
        end else begin
            m_out = m_out + gb - (resp ? 1 : 0);
        end
        m_out = m_out & 255;
        if (ldi) m_err = 0;
        case (m_mode)
            0: if (ld) m_mode = 1;
            1: if (!en) m_mode = 2;
            default: if (old_out == 0 && !resp) m_mode = 0;
        endcase
        if (gb != 0) begin
            m_tag = (m_tag + 1) % 256;
            m_rr  = (g + 1) % N;
        end
    endtask

    task automatic drain_idle();
        for (int c = 0; c < 100 && m_mode != 0; c++) step(0, 0, 0, m_out > 0, '1);
        checks++;
        if (m_mode != 0) begin
            errs++;
            $display("FAIL drain_timeout actual=mode%0d required=idle", m_mode);
        end
    endtask

    // Monitor: scoreboard pop on issue, accounting outputs vs model.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (command_valid_out) begin
                if (q.size() == 0) begin
                    checks++; errs++;
                    $display("FAIL unexpected_issue actual=src%0d required=none", command_src_out);
                end else begin
                    e = q.pop_front();
                    chk("issue_cmd", 256'(command_out), 256'(e.cmd));
                    chk("issue_src", 256'(command_src_out), 256'(e.src));
                    chk("issue_tag", 256'(command_tag_out), 256'(e.tag));
                end
            end else begin
                chk("missing_issue", 256'(q.size()), 256'(0));
            end
            chk("credits", 256'(credits_out), 256'(m_cred));
            chk("outstanding", 256'(outstanding_out), 256'(m_out));
            chk("overflow_err", 256'(credit_overflow_error), 256'(m_err));
            chk("drained", 256'(drained_out), 256'((m_mode == 2 && m_out == 0) ? 1 : 0));
        end
    end

    initial begin
        model_reset();
        #3;
        chk("reset_outputs", all_outs(), 256'(0));
        #9 rstn = 1'b1;

        // Basic issue: 4 credits, everyone requesting -> grants 0..3 then stall.
        step(1, 1, 4, 0, '1);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, '1);
        // One response frees a credit -> requester 4, tag 4, pointer wraps.
        step(1, 0, 0, 1, '1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, '1);
        // Return two credits, then grant + response in the same cycle.
        step(1, 0, 0, 1, 5'b00000);
        step(1, 0, 0, 1, 5'b00000);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, '1);
        // Drain with outstanding commands.
        step(0, 0, 0, 0, '1);
        step(0, 0, 0, 0, '1);
        drain_idle();

        // Overflow: load 2, no grants, a stray response; sticky until reload.
        step(1, 1, 2, 0, '0);
        step(1, 0, 0, 1, '0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, '0);
        step(1, 1, 7, 0, '0);                // ignored outside IDLE
        step(0, 0, 0, 0, '0);
        drain_idle();
        step(1, 1, 3, 0, '0);                // reload clears the error
        step(1, 0, 0, 0, '0);

        // Randomised operation, including disables, reload pulses and strays.
        for (int i = 0; i < 400; i++)
            step(($urandom % 10) != 0, ($urandom % 8) == 0, $urandom_range(0, 8),
                 (m_out > 0) ? bit'($urandom % 2) : bit'(($urandom % 16) == 0),
                 N'($urandom));
        drain_idle();

        // Tag wrap: 300 back-to-back grants with steady responses.
        step(1, 1, 255, 0, '1);
        for (int i = 0; i < 300; i++) step(1, 0, 0, m_out > 0, '1);

        // Async reset while a command is registered and another is granted.
        step(1, 0, 0, 0, '1);
        #2 rstn = 1'b0;
        #1;
        chk("reset_mid_issue", all_outs(), 256'(0));
        model_reset();
        @(negedge clock);
        #2 rstn = 1'b1;

        step(1, 1, 3, 0, '1);
        for (int i = 0; i < 30; i++)
            step(1, 0, 0, (m_out > 0) ? bit'($urandom % 2) : 1'b0, N'($urandom));
        step(1, 0, 0, 0, '0);
        step(1, 0, 0, 0, '0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
